// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues single outstanding imem requests and
// presents the fetched instruction to the decoder with a valid flag.
module instr_fetch_unit #(
   parameter int unsigned           XLEN      = 32,
   parameter logic [XLEN-1:0]       RESET_PC  = '0,
   parameter logic [XLEN-1:0]       NOP_INSTR = XLEN'(32'h0000_0013)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pcsrc,
   input  logic [XLEN-1:0] immext,
   input  logic            stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] instr,
   output logic            instr_valid,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            fetch_err
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      VALID = 3'd3,
      ERR   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;
   logic [XLEN-1:0] target;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   // Next-PC wraps modulo 2^XLEN through natural adder overflow.
   assign pc_plus4 = pc_q + XLEN'(4);
   assign target   = pcsrc ? (pc_q + immext) : pc_plus4;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      err_d   = err_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (imem_gnt) begin
               if (imem_rvalid) begin
                  instr_d = imem_rdata;
                  valid_d = 1'b1;
                  state_d = VALID;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               instr_d = imem_rdata;
               valid_d = 1'b1;
               state_d = VALID;
            end
         end
         VALID: begin
            if (!stall) begin
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               if (target[1:0] == 2'b00) begin
                  pc_d    = target;
                  state_d = REQ;
               end else begin
                  err_d   = 1'b1;
                  state_d = ERR;
               end
            end
         end
         ERR:     state_d = ERR;
         default: state_d = IDLE;
      endcase
   end

   assign imem_req    = (state_q == REQ);
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected fetch addresses and
// instructions are queued by the stimulus and checked by a monitor.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        pcsrc;
   logic [31:0] immext;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_err;

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [31:0] addr_q[$];
   logic [31:0] ins_q[$];
   logic [31:0] pc_q[$];

   instr_fetch_unit #(
      .XLEN(32),
      .RESET_PC(32'h0000_0000),
      .NOP_INSTR(32'h0000_0013)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .pcsrc(pcsrc),
      .immext(immext),
      .stall(stall),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata),
      .instr(instr),
      .instr_valid(instr_valid),
      .pc(pc),
      .pc_plus4(pc_plus4),
      .fetch_err(fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout/unexpected expected event", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_fetch(input logic [31:0] a, input logic [31:0] d);
      addr_q.push_back(a);
      ins_q.push_back(d);
      pc_q.push_back(a);
   endtask

   // Consume the current VALID instruction, serve the next fetch with
   // same-cycle gnt/rvalid, and park stalled in the new VALID.
   task automatic advance(input logic ps, input logic [31:0] imm,
                          input logic [31:0] ea, input logic [31:0] rd);
      bit got;
      got = 0;
      stall = 0; pcsrc = ps; immext = imm;
      expect_fetch(ea, rd);
      imem_gnt = 1; imem_rvalid = 1; imem_rdata = rd;
      for (int i = 0; i < 10; i++) begin
         step();
         pcsrc = 0; immext = '0;
         if (instr_valid) begin
            stall = 1; imem_gnt = 0; imem_rvalid = 0;
            got = 1;
            break;
         end
      end
      if (!got) fail_now("advance_timeout");
   endtask

   // Monitor: checks every granted request and every newly valid instruction.
   initial begin
      logic vprev;
      logic [31:0] e;
      vprev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && imem_req && imem_gnt) begin
            if (addr_q.size() == 0) fail_now("unexpected_request");
            else begin
               e = addr_q.pop_front();
               check("imem_addr", imem_addr, e);
            end
         end
         if (instr_valid && !vprev) begin
            if (ins_q.size() == 0) fail_now("unexpected_instr");
            else begin
               e = ins_q.pop_front();
               check("instr", instr, e);
               e = pc_q.pop_front();
               check("instr_pc", pc, e);
            end
         end
         vprev = instr_valid;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit found;
      int unsigned reqs;
      int vidx;

      rst_n = 0; pcsrc = 0; immext = '0; stall = 0;
      imem_gnt = 1; imem_rvalid = 1; imem_rdata = 32'h0050_0093;
      step(); step();
      check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_instr", instr, 32'h0000_0013);
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
      check("rst_pc", pc, 32'h0);
      check("rst_pc_plus4", pc_plus4, 32'h4);

      // Back-to-back fetches at best-case throughput.
      expect_fetch(32'h0, 32'h0050_0093);
      expect_fetch(32'h4, 32'h0050_0093);
      expect_fetch(32'h8, 32'h0050_0093);
      rst_n = 1;
      found = 0;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (instr_valid && pc == 32'h8) begin
            check("third_valid_cycle", 32'(c), 32'd6);
            stall = 1; imem_gnt = 0; imem_rvalid = 0;
            pcsrc = 1; immext = 32'h40;
            found = 1;
            break;
         end
      end
      if (!found) fail_now("burst_timeout");

      // Stall holds PC/instr while pcsrc toggles.
      for (int k = 0; k < 4; k++) begin
         step();
         check("stall_pc", pc, 32'h8);
         check("stall_instr", instr, 32'h0050_0093);
         check("stall_valid", {31'd0, instr_valid}, 32'd1);
         check("stall_req", {31'd0, imem_req}, 32'd0);
         pcsrc = (k % 2 == 0) ? 1'b0 : 1'b1;
         immext = 32'h40;
      end
      stall = 0; pcsrc = 0; immext = '0;

      // Delayed grant, then delayed rvalid; stray rvalid before grant.
      expect_fetch(32'hC, 32'h00A0_0113);
      reqs = 0; vidx = -1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (imem_req) reqs++;
         if (instr_valid && vidx < 0) begin
            vidx = i;
            stall = 1;
         end
         imem_gnt    = (i == 3);
         imem_rvalid = (i == 1) || (i == 5);
         imem_rdata  = (i == 5) ? 32'h00A0_0113 : 32'hDEAD_BEEF;
      end
      imem_gnt = 0; imem_rvalid = 0;
      check("req_cycles", 32'(reqs), 32'd4);
      check("valid_after_rvalid", 32'(vidx), 32'd6);

      // Sequential to 0x10, then backward branch to 0x08, then to 0x00.
      advance(1'b0, 32'h0, 32'h10, 32'h00C0_0193);
      check("pc_at_10", pc, 32'h10);
      check("pc_plus4_at_10", pc_plus4, 32'h14);
      advance(1'b1, 32'hFFFF_FFF8, 32'h08, 32'h0040_0213);
      advance(1'b1, 32'hFFFF_FFF8, 32'h00, 32'h0050_0293);

      // Misaligned target enters the terminal error state.
      stall = 0; pcsrc = 1; immext = 32'h2;
      step();
      pcsrc = 0; immext = '0;
      check("err_flag", {31'd0, fetch_err}, 32'd1);
      check("err_valid", {31'd0, instr_valid}, 32'd0);
      check("err_pc", pc, 32'h0);
      check("err_instr", instr, 32'h0000_0013);
      imem_gnt = 1; imem_rvalid = 1;
      for (int k = 0; k < 5; k++) begin
         step();
         check("err_no_req", {31'd0, imem_req}, 32'd0);
         check("err_sticky", {31'd0, fetch_err}, 32'd1);
      end

      // Reset clears the error immediately.
      rst_n = 0;
      #1;
      check("rst_clears_err", {31'd0, fetch_err}, 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_req_low", {31'd0, imem_req}, 32'd0);
      imem_gnt = 1; imem_rvalid = 0;
      step();
      rst_n = 1;
      expect_fetch(32'h0, 32'h0010_0093);
      pc_q.pop_back();
      ins_q.pop_back();
      step();
      check("fresh_req", {31'd0, imem_req}, 32'd1);
      step();
      check("wait_req_low", {31'd0, imem_req}, 32'd0);
      imem_gnt = 0;

      // Reset while in WAIT; the late response must be dropped.
      rst_n = 0;
      #1;
      check("midrst_valid", {31'd0, instr_valid}, 32'd0);
      check("midrst_pc", pc, 32'h0);
      step();
      rst_n = 1; imem_rvalid = 1; imem_rdata = 32'hBAAD_F00D;
      step();
      imem_rvalid = 0;
      check("post_rst_req", {31'd0, imem_req}, 32'd1);
      check("post_rst_addr", imem_addr, 32'h0);
      check("post_rst_valid", {31'd0, instr_valid}, 32'd0);
      check("post_rst_instr", instr, 32'h0000_0013);
      expect_fetch(32'h0, 32'h0010_0093);
      imem_gnt = 1; imem_rvalid = 1; imem_rdata = 32'h0010_0093;
      found = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (instr_valid) begin
            stall = 1; imem_gnt = 0; imem_rvalid = 0;
            found = 1;
            break;
         end
      end
      if (!found) fail_now("post_rst_fetch_timeout");

      step(); step();
      check("addr_queue_empty", 32'(addr_q.size()), 32'd0);
      check("instr_queue_empty", 32'(ins_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
